// File: rtl/multiplier_accum_stage.sv
// Window accumulator behind the x23027 constant multiplier: sums LEN products
// and hands each sum downstream over a registered valid/ready output.
module multiplier_accum_stage #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN    = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ACC_W-1:0]  o_data,
    output logic              o_ovf
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] data_q, data_d;

    logic             lastSlot;
    logic             accept;
    logic [ACC_W:0]   sum;

    assign lastSlot = (cnt_q == LastCnt);
    assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_data};

    // Only the window-closing product is held back, and only while the
    // previous result is still unclaimed; o_ready frees it in the same cycle.
    assign i_ready = !rst && !i_clear && !(valid_q && !o_ready && lastSlot);
    assign accept  = i_valid && i_ready;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end

        // Clear restarts the window but leaves any pending result alone.
        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
            if (lastSlot) begin
                data_d  = sum[ACC_W-1:0];
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_multiplier_accum_stage.sv
// Directed bench for multiplier_accum_stage: three instances cover LEN=4,
// the 32-bit overflow case with LEN=2, and LEN=1 streaming.
module tb_multiplier_accum_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        aValid, aReady, aClear, aOValid, aOReady, aOvf;
    logic [31:0] aData;
    logic [39:0] aOData;

    logic        bValid, bReady, bClear, bOValid, bOReady, bOvf;
    logic [31:0] bData;
    logic [31:0] bOData;

    logic        cValid, cReady, cClear, cOValid, cOReady, cOvf;
    logic [31:0] cData;
    logic [39:0] cOData;

    int checks = 0;
    int errors = 0;

    multiplier_accum_stage #(.DATA_W(32), .ACC_W(40), .LEN(4), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst), .i_valid(aValid), .i_ready(aReady), .i_data(aData),
        .i_clear(aClear), .o_valid(aOValid), .o_ready(aOReady), .o_data(aOData), .o_ovf(aOvf)
    );

    multiplier_accum_stage #(.DATA_W(32), .ACC_W(32), .LEN(2), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .i_valid(bValid), .i_ready(bReady), .i_data(bData),
        .i_clear(bClear), .o_valid(bOValid), .o_ready(bOReady), .o_data(bOData), .o_ovf(bOvf)
    );

    multiplier_accum_stage #(.DATA_W(32), .ACC_W(40), .LEN(1), .CNT_W(8)) dutC (
        .clk(clk), .rst(rst), .i_valid(cValid), .i_ready(cReady), .i_data(cData),
        .i_clear(cClear), .o_valid(cOValid), .o_ready(cOReady), .o_data(cOData), .o_ovf(cOvf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives instance A and lets the combinational i_ready settle.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic clr, input logic ordy);
        aValid  = v;
        aData   = d;
        aClear  = clr;
        aOReady = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        aValid = 0; aData = 0; aClear = 0; aOReady = 0;
        bValid = 0; bData = 0; bClear = 0; bOReady = 0;
        cValid = 0; cData = 0; cClear = 0; cOReady = 0;
        #12;
        checkOutput("rst oValid", aOValid, 0);
        checkOutput("rst oData", aOData, 0);
        checkOutput("rst ovf", aOvf, 0);
        checkOutput("rst iReady", aReady, 0);
        checkOutput("rst iReadyB", bReady, 0);
        checkOutput("rst iReadyC", cReady, 0);
        @(negedge clk);
        rst = 1'b0;

        // Four products, downstream always ready: one-cycle result pulse.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 23027, 0, 1);
            checkOutput("t1 iReady", aReady, 1);
            checkOutput("t1 oValid early", aOValid, 0);
            tick();
        end
        checkOutput("t1 oValid", aOValid, 1);
        checkOutput("t1 oData", aOData, 40'd92108);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1 iReady idle", aReady, 1);
        tick();
        checkOutput("t1 oValid drop", aOValid, 0);

        // Downstream stalled: next window fills but its last product waits.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 23027, 0, 0);
            tick();
        end
        checkOutput("t2 oValid", aOValid, 1);
        checkOutput("t2 oData", aOData, 40'd92108);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 23027, 0, 0);
            checkOutput("t2 iReady mid", aReady, 1);
            tick();
            checkOutput("t2 hold valid", aOValid, 1);
            checkOutput("t2 hold data", aOData, 40'd92108);
        end
        applyStimulus(1, 23027, 0, 0);
        checkOutput("t2 stall", aReady, 0);
        tick();
        checkOutput("t2 stall valid", aOValid, 1);
        checkOutput("t2 stall data", aOData, 40'd92108);
        applyStimulus(1, 23027, 0, 1);
        checkOutput("t2 release", aReady, 1);
        tick();
        checkOutput("t2 b2b valid", aOValid, 1);
        checkOutput("t2 b2b data", aOData, 40'd92108);
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("t2 drain", aOValid, 0);

        // Clear discards a partial window.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 23027, 0, 1);
            tick();
        end
        applyStimulus(1, 23027, 1, 1);
        checkOutput("t4 clear iReady", aReady, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 46054, 0, 1);
            tick();
            if (k < 3) checkOutput("t4 no early sum", aOValid, 0);
        end
        checkOutput("t4 oValid", aOValid, 1);
        checkOutput("t4 oData", aOData, 40'd184216);
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("t4 drain", aOValid, 0);

        // Asynchronous reset with a held result and a partial window.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 23027, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5 pre oValid", aOValid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5 async oValid", aOValid, 0);
        checkOutput("t5 async oData", aOData, 0);
        checkOutput("t5 async ovf", aOvf, 0);
        checkOutput("t5 async iReady", aReady, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 32'(k * 1000), 0, 1);
            tick();
        end
        checkOutput("t5 fresh valid", aOValid, 1);
        checkOutput("t5 fresh data", aOData, 40'd10000);
        applyStimulus(0, 0, 0, 1);
        tick();

        // 32-bit accumulator carry-out sets the sticky flag; clear drops it.
        bOReady = 1; bValid = 1; bData = 32'hFFFF_FFFF;
        tick();
        bData = 32'h0000_0002;
        tick();
        checkOutput("t3 oValid", bOValid, 1);
        checkOutput("t3 oData", bOData, 32'h0000_0001);
        checkOutput("t3 ovf", bOvf, 1);
        bValid = 0; bClear = 1;
        #1;
        checkOutput("t3 clear iReady", bReady, 0);
        tick();
        bClear = 0;
        checkOutput("t3 ovf cleared", bOvf, 0);
        checkOutput("t3 data kept", bOData, 32'h0000_0001);

        // LEN=1 streams one result per accepted product.
        cOReady = 1;
        for (int k = 1; k <= 3; k++) begin
            cValid = 1; cData = 32'(k);
            #1;
            checkOutput("t6 iReady", cReady, 1);
            tick();
            checkOutput("t6 oValid", cOValid, 1);
            checkOutput("t6 oData", cOData, 40'(k));
        end
        cValid = 0;
        tick();
        checkOutput("t6 drain", cOValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
